pass_controller: RTL

Responder end of the scheduler's pass handshake. It accepts a pass request on `pass_start` when `pass_ready` is high, then runs the pass's NoC/PE phases in a fixed order: filter+ifmap load, bias or psum preload, compute, psum store. It returns a single-cycle `pass_done` when the pass completes. It sits between the layer scheduler and the GLB/NoC/PE-array phase engines, and adds a per-phase watchdog and a completed-pass counter.

---
 rtl/pass_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pass_controller.sv
`default_nettype none
// ============================================================================
// Module  : pass_controller
// Brief   : Responder side of the scheduler pass handshake. Sequences the
//           load / preload / compute / store phases, with a per-phase watchdog
//           and a completed-pass counter.
// Revision: 1.0  initial release
// ============================================================================
module pass_controller #(
    parameter int TO_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pass_start,
    output logic                 pass_ready,
    output logic                 pass_done,
    input  logic                 bias_sel,
    output logic                 filter_load_start,
    output logic                 ifmap_load_start,
    input  logic                 filter_load_done,
    input  logic                 ifmap_load_done,
    output logic                 bias_load_start,
    output logic                 psum_load_start,
    input  logic                 bias_load_done,
    input  logic                 psum_load_done,
    output logic                 compute_start,
    input  logic                 compute_done,
    output logic                 psum_store_start,
    input  logic                 psum_store_done,
    output logic [2:0]           phase,
    output logic                 error,
    output logic [2:0]           error_phase,
    output logic [CNT_WIDTH-1:0] pass_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PRELOAD = 3'd2,
        COMPUTE = 3'd3,
        STORE   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } state_t;

    localparam bit                C_WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_WIDTH-1:0] C_TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    logic                r_bias_q;
    logic                r_f_seen;
    logic                r_i_seen;
    logic [TO_WIDTH-1:0] r_wdog;

    logic                w_done;
    logic                w_timeout;

    assign pass_ready = (r_state == IDLE);
    assign phase      = r_state;

    // Completing condition of the current waiting phase; a done pulse in the
    // same cycle as the last load flag still counts.
    always_comb begin
        w_done = 1'b0;
        case (r_state)
            LOAD:    w_done = (r_f_seen | filter_load_done) & (r_i_seen | ifmap_load_done);
            PRELOAD: w_done = r_bias_q ? bias_load_done : psum_load_done;
            COMPUTE: w_done = compute_done;
            STORE:   w_done = psum_store_done;
            default: w_done = 1'b0;
        endcase
    end

    assign w_timeout = C_WD_EN && (r_wdog == C_TO_LAST) && !w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= IDLE;
            r_bias_q          <= 1'b0;
            r_f_seen          <= 1'b0;
            r_i_seen          <= 1'b0;
            r_wdog            <= '0;
            pass_done         <= 1'b0;
            filter_load_start <= 1'b0;
            ifmap_load_start  <= 1'b0;
            bias_load_start   <= 1'b0;
            psum_load_start   <= 1'b0;
            compute_start     <= 1'b0;
            psum_store_start  <= 1'b0;
            error             <= 1'b0;
            error_phase       <= 3'd0;
            pass_count        <= '0;
        end else begin
            pass_done         <= 1'b0;
            filter_load_start <= 1'b0;
            ifmap_load_start  <= 1'b0;
            bias_load_start   <= 1'b0;
            psum_load_start   <= 1'b0;
            compute_start     <= 1'b0;
            psum_store_start  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (pass_start) begin
                        r_state           <= LOAD;
                        r_bias_q          <= bias_sel;
                        r_f_seen          <= 1'b0;
                        r_i_seen          <= 1'b0;
                        r_wdog            <= '0;
                        filter_load_start <= 1'b1;
                        ifmap_load_start  <= 1'b1;
                    end
                end
                LOAD, PRELOAD, COMPUTE, STORE: begin
                    if (w_timeout) begin
                        r_state     <= ERROR;
                        error       <= 1'b1;
                        error_phase <= r_state;
                    end else if (w_done) begin
                        r_wdog <= '0;
                        case (r_state)
                            LOAD: begin
                                r_state         <= PRELOAD;
                                bias_load_start <= r_bias_q;
                                psum_load_start <= ~r_bias_q;
                            end
                            PRELOAD: begin
                                r_state       <= COMPUTE;
                                compute_start <= 1'b1;
                            end
                            COMPUTE: begin
                                r_state          <= STORE;
                                psum_store_start <= 1'b1;
                            end
                            default: begin
                                r_state   <= DONE;
                                pass_done <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                        if (r_state == LOAD) begin
                            r_f_seen <= r_f_seen | filter_load_done;
                            r_i_seen <= r_i_seen | ifmap_load_done;
                        end
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    pass_count <= pass_count + 1'b1;
                end
                default: begin
                    // ERROR is terminal until reset
                    r_state <= ERROR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
